// File: rtl/uart_rx_packer_pkg.sv
// uart_rx_packer_pkg: shared types and constants for the UART receive packer
package uart_rx_packer_pkg;
    localparam int BYTE_W  = 8;
    localparam int MIN_DIV = 2;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_rx_packer_if.sv
// uart_rx_packer_if: write port into the rx FIFO
interface uart_rx_packer_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_en;
    logic              fifo_full;
    modport master (output fifo_data, fifo_en, input fifo_full);
    modport slave  (input fifo_data, fifo_en, output fifo_full);
endinterface

// File: rtl/uart_rx_packer_bit_timer.sv
// uart_rx_packer_bit_timer: loadable down-counter; tick while running at zero
module uart_rx_packer_bit_timer #(
    parameter int W = 16
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] load_val,
    output logic         tick
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (run && cnt != '0) cnt <= cnt - 1'b1;

    assign tick = run && cnt == '0;
endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer: oversampling 8N1 deframer that packs byte pairs (low first)
// into 16-bit FIFO words, flagging framing errors and overruns as pulses.
module uart_rx_packer
    import uart_rx_packer_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int DIV_W        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TO_BITS = 20
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_divisor,
    uart_rx_packer_if.master fifo,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int TW = DIV_W + 5;

    rx_state_e              state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_d, fall, phase_hi, push_pending;
    logic [2:0]             bit_idx;
    logic [BYTE_W-1:0]      shreg, lo_byte;
    logic [DATA_W-1:0]      word;
    logic [DIV_W-1:0]       div_q, eff_div, bt_val;
    logic [TW-1:0]          to_val;
    logic                   bt_load, bt_run, bt_tick, to_idle_hi, to_tick;

    assign rx_s       = sync[SYNC_STAGES-1];
    assign fall       = rx_d & ~rx_s;
    assign eff_div    = baud_divisor < DIV_W'(MIN_DIV) ? DIV_W'(MIN_DIV) : baud_divisor;
    assign bt_load    = (state == IDLE && fall && enable) ||
                        (bt_tick && (state == DATA || (state == START && !rx_s)));
    // the half-bit load happens while still in IDLE, before div_q is latched
    assign bt_val     = state == IDLE ? (eff_div >> 1) - 1'b1 : div_q - 1'b1;
    assign bt_run     = state == START || state == DATA || state == STOP;
    assign to_idle_hi = state == IDLE && phase_hi;
    assign to_val     = TW'(IDLE_TO_BITS) * TW'(div_q) - 1'b1;
    assign busy       = state != IDLE || phase_hi;

    uart_rx_packer_bit_timer #(.W(DIV_W)) u_bit_timer (
        .clk(clk), .rst(rst), .load(bt_load), .run(bt_run), .load_val(bt_val), .tick(bt_tick)
    );

    // the alignment timer is reloaded whenever the idle-with-half-word window is broken
    uart_rx_packer_bit_timer #(.W(TW)) u_to_timer (
        .clk(clk), .rst(rst), .load(!to_idle_hi), .run(to_idle_hi), .load_val(to_val), .tick(to_tick)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync           <= '1;
            rx_d           <= 1'b1;
            state          <= IDLE;
            bit_idx        <= '0;
            shreg          <= '0;
            lo_byte        <= '0;
            word           <= '0;
            div_q          <= '0;
            phase_hi       <= 1'b0;
            push_pending   <= 1'b0;
            fifo.fifo_en   <= 1'b0;
            fifo.fifo_data <= '0;
            frame_err      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], rx};
            rx_d         <= rx_s;
            fifo.fifo_en <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            push_pending <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                phase_hi <= 1'b0;
            end else begin
                if (push_pending) begin
                    if (!fifo.fifo_full) begin
                        fifo.fifo_en   <= 1'b1;
                        fifo.fifo_data <= word;
                    end else overrun <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (to_tick) phase_hi <= 1'b0;
                        if (fall) begin
                            state <= START;
                            div_q <= eff_div;
                        end
                    end
                    START: if (bt_tick) begin
                        state   <= rx_s ? IDLE : DATA;
                        bit_idx <= '0;
                    end
                    DATA: if (bt_tick) begin
                        shreg   <= {rx_s, shreg[BYTE_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(BYTE_W - 1)) state <= STOP;
                    end
                    STOP: if (bt_tick) begin
                        if (rx_s) begin
                            state    <= IDLE;
                            phase_hi <= !phase_hi;
                            if (phase_hi) begin
                                word         <= {shreg, lo_byte};
                                push_pending <= 1'b1;
                            end else lo_byte <= shreg;
                        end else begin
                            state     <= BREAK;
                            phase_hi  <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    BREAK: if (rx_s) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
endmodule
